// File: rtl/bp_be_stride_prefetch_engine_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bp_be_stride_prefetch_engine_if: training and prefetch-issue bus  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface bp_be_stride_prefetch_engine_if #(
  parameter int VADDR_WIDTH  = 39,
  parameter int STRIDE_WIDTH = 12
);
  logic                    mem_v_i;
  logic [VADDR_WIDTH-1:0]  mem_pc_i;
  logic [VADDR_WIDTH-1:0]  mem_addr_i;
  logic                    pf_v_o;
  logic [VADDR_WIDTH-1:0]  pf_addr_o;
  logic [VADDR_WIDTH-1:0]  pf_pc_o;
  logic [STRIDE_WIDTH-1:0] pf_stride_o;
  logic                    pf_yumi_i;

  modport master (
    output mem_v_i, mem_pc_i, mem_addr_i, pf_yumi_i,
    input  pf_v_o, pf_addr_o, pf_pc_o, pf_stride_o
  );

  modport slave (
    input  mem_v_i, mem_pc_i, mem_addr_i, pf_yumi_i,
    output pf_v_o, pf_addr_o, pf_pc_o, pf_stride_o
  );
endinterface
`default_nettype wire

// File: rtl/bp_be_stride_prefetch_engine.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bp_be_stride_prefetch_engine: multi-stream stride detector and    |
// | filtered prefetch burst issuer.                    Rev 1.0        |
// +------------------------------------------------------------------+
module bp_be_stride_prefetch_engine #(
  parameter int VADDR_WIDTH  = 39,
  parameter int STREAMS      = 8,
  parameter int STRIDE_WIDTH = 12,
  parameter int CONF_WIDTH   = 2,
  parameter int CONF_THRESH  = 2,
  parameter int DISTANCE     = 1,
  parameter int DEGREE       = 4,
  parameter int FILTER_ELS   = 4
) (
  input  wire logic                    clk_i,
  input  wire logic                    reset_i,
  input  wire logic                    flush_i,
  bp_be_stride_prefetch_engine_if.slave bus,
  output      logic                    busy_o,
  output      logic                    trigger_drop_o
);

  localparam int IDX_W = (STREAMS > 1) ? $clog2(STREAMS) : 1;
  localparam int K_W   = $clog2(DISTANCE + DEGREE) + 1;

  localparam logic [K_W-1:0]        C_K_FIRST     = K_W'(DISTANCE);
  localparam logic [K_W-1:0]        C_K_LAST      = K_W'(DISTANCE + DEGREE - 1);
  localparam logic [CONF_WIDTH-1:0] C_CONF_MAX    = '1;
  localparam logic [CONF_WIDTH-1:0] C_CONF_THRESH = CONF_WIDTH'(CONF_THRESH);
  localparam logic [IDX_W-1:0]      C_IDX_LAST    = IDX_W'(STREAMS - 1);

  localparam logic [0:0] E_IDLE  = 1'b0;
  localparam logic [0:0] E_ISSUE = 1'b1;

  logic [STREAMS-1:0]      r_valid;
  logic [VADDR_WIDTH-1:0]  r_tag    [STREAMS];
  logic [VADDR_WIDTH-1:0]  r_last   [STREAMS];
  logic [STRIDE_WIDTH-1:0] r_stride [STREAMS];
  logic [CONF_WIDTH-1:0]   r_conf   [STREAMS];
  logic [IDX_W-1:0]        r_victim;

  logic [0:0]              r_state;
  logic [VADDR_WIDTH-1:0]  r_base;
  logic [VADDR_WIDTH-1:0]  r_pc;
  logic [STRIDE_WIDTH-1:0] r_strd;
  logic [K_W-1:0]          r_k;
  logic [VADDR_WIDTH-1:0]  r_filt   [FILTER_ELS];
  logic [FILTER_ELS-1:0]   r_filt_v;
  logic                    r_drop;

  logic                    w_train;
  logic                    w_hit;
  logic [IDX_W-1:0]        w_hit_idx;
  logic                    w_free;
  logic [IDX_W-1:0]        w_free_idx;
  logic [IDX_W-1:0]        w_alloc_idx;
  logic [VADDR_WIDTH-1:0]  w_delta_full;
  logic [STRIDE_WIDTH-1:0] w_delta;
  logic                    w_fits;
  logic [STRIDE_WIDTH-1:0] w_old_stride;
  logic [CONF_WIDTH-1:0]   w_old_conf;
  logic                    w_match;
  logic [CONF_WIDTH-1:0]   w_new_conf;
  logic [STRIDE_WIDTH-1:0] w_new_stride;
  logic                    w_trigger;
  logic [VADDR_WIDTH-1:0]  w_stride_sext;
  logic [VADDR_WIDTH-1:0]  w_target;
  logic                    w_filt_hit;
  logic                    w_issuing;
  logic                    w_pf_v;
  logic                    w_advance;
  logic                    w_done;
  logic                    w_accept;

  assign w_train = bus.mem_v_i && !flush_i;

  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int i = 0; i < STREAMS; i++) begin
      if (r_valid[i] && (r_tag[i] == bus.mem_pc_i)) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
    end
    for (int i = STREAMS - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free     = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  assign w_alloc_idx  = w_free ? w_free_idx : r_victim;
  assign w_old_stride = r_stride[w_hit_idx];
  assign w_old_conf   = r_conf[w_hit_idx];
  assign w_delta_full = bus.mem_addr_i - r_last[w_hit_idx];
  assign w_delta      = w_delta_full[STRIDE_WIDTH-1:0];
  // A delta that would not survive truncation must never look like a match.
  assign w_fits       = (w_delta_full[VADDR_WIDTH-1:STRIDE_WIDTH-1] == '0) ||
                        (w_delta_full[VADDR_WIDTH-1:STRIDE_WIDTH-1] == '1);
  assign w_match      = w_fits && (w_delta == w_old_stride);

  always_comb begin
    w_new_stride = w_old_stride;
    if (w_match) begin
      w_new_conf = (w_old_conf == C_CONF_MAX) ? w_old_conf : w_old_conf + 1'b1;
    end else if (w_old_conf == '0) begin
      w_new_conf   = '0;
      w_new_stride = w_delta;
    end else begin
      w_new_conf = w_old_conf - 1'b1;
    end
  end

  assign w_trigger = w_train && w_hit && w_match && (w_old_stride != '0) &&
                     (w_new_conf >= C_CONF_THRESH);

  assign w_stride_sext = {{(VADDR_WIDTH - STRIDE_WIDTH){r_strd[STRIDE_WIDTH-1]}}, r_strd};
  assign w_target      = r_base + VADDR_WIDTH'(r_k) * w_stride_sext;

  always_comb begin
    w_filt_hit = 1'b0;
    for (int i = 0; i < FILTER_ELS; i++) begin
      if (r_filt_v[i] && (r_filt[i] == w_target)) w_filt_hit = 1'b1;
    end
  end

  assign w_issuing = (r_state == E_ISSUE);
  assign w_pf_v    = w_issuing && !w_filt_hit;
  assign w_advance = w_issuing && (w_filt_hit || bus.pf_yumi_i);
  assign w_done    = w_advance && (r_k == C_K_LAST);
  assign w_accept  = w_trigger && (!w_issuing || w_done);

  assign bus.pf_v_o      = w_pf_v;
  assign bus.pf_addr_o   = w_pf_v ? w_target : '0;
  assign bus.pf_pc_o     = w_pf_v ? r_pc : '0;
  assign bus.pf_stride_o = w_pf_v ? r_strd : '0;
  assign busy_o          = w_issuing;
  assign trigger_drop_o  = r_drop;

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      r_valid  <= '0;
      r_victim <= '0;
    end else if (bus.mem_v_i) begin
      if (w_hit) begin
        r_last[w_hit_idx]   <= bus.mem_addr_i;
        r_stride[w_hit_idx] <= w_new_stride;
        r_conf[w_hit_idx]   <= w_new_conf;
      end else begin
        r_valid[w_alloc_idx]  <= 1'b1;
        r_tag[w_alloc_idx]    <= bus.mem_pc_i;
        r_last[w_alloc_idx]   <= bus.mem_addr_i;
        r_stride[w_alloc_idx] <= '0;
        r_conf[w_alloc_idx]   <= '0;
        if (!w_free) r_victim <= (r_victim == C_IDX_LAST) ? '0 : r_victim + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      r_state  <= E_IDLE;
      r_base   <= '0;
      r_pc     <= '0;
      r_strd   <= '0;
      r_k      <= '0;
      r_filt_v <= '0;
      r_drop   <= 1'b0;
    end else begin
      r_drop <= w_trigger && !w_accept;
      if (w_pf_v && bus.pf_yumi_i) begin
        r_filt[0]   <= w_target;
        r_filt_v[0] <= 1'b1;
        for (int i = 1; i < FILTER_ELS; i++) begin
          r_filt[i]   <= r_filt[i-1];
          r_filt_v[i] <= r_filt_v[i-1];
        end
      end
      if (w_accept) begin
        r_state <= E_ISSUE;
        r_base  <= bus.mem_addr_i;
        r_pc    <= bus.mem_pc_i;
        r_strd  <= w_old_stride;
        r_k     <= C_K_FIRST;
      end else if (w_done) begin
        r_state <= E_IDLE;
      end else if (w_advance) begin
        r_k <= r_k + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bp_be_stride_prefetch_engine.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_bp_be_stride_prefetch_engine: directed stimulus, queue-based   |
// | scoreboard for the prefetch stream.                Rev 1.0        |
// +------------------------------------------------------------------+
module tb_bp_be_stride_prefetch_engine;

  typedef struct packed {
    logic [38:0] addr;
    logic [38:0] pc;
    logic [11:0] stride;
  } exp_t;

  logic clk_i = 1'b0;
  logic reset_i;
  logic flush_i;
  logic busy_o;
  logic trigger_drop_o;

  int   n_tests  = 0;
  int   n_fail   = 0;
  int   drop_cnt = 0;
  int   hold     = 0;
  bit   mon_en   = 1'b0;
  exp_t q[$];

  bp_be_stride_prefetch_engine_if bus ();

  bp_be_stride_prefetch_engine dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .flush_i        (flush_i),
    .bus            (bus),
    .busy_o         (busy_o),
    .trigger_drop_o (trigger_drop_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic op(input logic [38:0] pc, input logic [38:0] addr);
    bus.mem_v_i    = 1'b1;
    bus.mem_pc_i   = pc;
    bus.mem_addr_i = addr;
    @(posedge clk_i); #1;
    bus.mem_v_i    = 1'b0;
  endtask

  task automatic push(input logic [38:0] addr, input logic [38:0] pc, input logic [11:0] stride);
    exp_t e;
    e.addr = addr; e.pc = pc; e.stride = stride;
    q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk_i); #1;
      if (!busy_o && q.size() == 0) break;
    end
    chk({name, "_busy"}, 64'(busy_o), 64'd0);
    chk({name, "_drained"}, 64'(q.size()), 64'd0);
  endtask

  // Monitor: compares the presented request every cycle, pops only on handshake.
  always @(negedge clk_i) begin
    if (trigger_drop_o) drop_cnt++;
    if (mon_en && bus.pf_v_o) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pf: got addr %0h required no request", bus.pf_addr_o);
        bus.pf_yumi_i = 1'b1;
      end else begin
        chk("pf_addr", 64'(bus.pf_addr_o), 64'(q[0].addr));
        chk("pf_pc", 64'(bus.pf_pc_o), 64'(q[0].pc));
        chk("pf_stride", 64'(bus.pf_stride_o), 64'(q[0].stride));
        if (hold > 0) begin
          hold--;
          bus.pf_yumi_i = 1'b0;
        end else begin
          bus.pf_yumi_i = 1'b1;
          void'(q.pop_front());
        end
      end
    end else begin
      bus.pf_yumi_i = 1'b0;
    end
  end

  initial begin
    reset_i        = 1'b1;
    flush_i        = 1'b0;
    bus.mem_v_i    = 1'b0;
    bus.mem_pc_i   = '0;
    bus.mem_addr_i = '0;
    bus.pf_yumi_i  = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_pf_v", 64'(bus.pf_v_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_drop", 64'(trigger_drop_o), 64'd0);
    chk("rst_addr", 64'(bus.pf_addr_o), 64'd0);
    reset_i = 1'b0;

    // Reset while a burst is pending; the table must come back empty.
    op(39'h700, 39'h8000); op(39'h700, 39'h8004); op(39'h700, 39'h8008); op(39'h700, 39'h800C);
    chk("burst_pending", 64'(bus.pf_v_o), 64'd1);
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    chk("midrst_pf_v", 64'(bus.pf_v_o), 64'd0);
    chk("midrst_busy", 64'(busy_o), 64'd0);
    mon_en = 1'b1;
    op(39'h700, 39'h8010); op(39'h700, 39'h8014); op(39'h700, 39'h8018);
    for (int i = 0; i < 4; i++) push(39'h8020 + 39'(4 * i), 39'h700, 12'h004);
    op(39'h700, 39'h801C);
    wait_idle("post_reset");

    // Positive stride, then filter suppression on the overlapping burst.
    op(39'h100, 39'h1000); op(39'h100, 39'h1040); op(39'h100, 39'h1080);
    chk("pretrain_busy", 64'(busy_o), 64'd0);
    for (int i = 0; i < 4; i++) push(39'h1100 + 39'(64 * i), 39'h100, 12'h040);
    op(39'h100, 39'h10C0);
    chk("latency_pf_v", 64'(bus.pf_v_o), 64'd1);
    wait_idle("pos_burst");
    push(39'h1200, 39'h100, 12'h040);
    op(39'h100, 39'h1100);
    wait_idle("filtered");

    // Negative stride with the first request stalled three cycles.
    hold = 3;
    op(39'h400, 39'h2000); op(39'h400, 39'h1FF8); op(39'h400, 39'h1FF0);
    for (int i = 0; i < 4; i++) push(39'h1FE0 - 39'(8 * i), 39'h400, 12'hFF8);
    op(39'h400, 39'h1FE8);
    wait_idle("neg_burst");

    // Second stream triggers while the first burst is running.
    op(39'h200, 39'h3000); op(39'h200, 39'h3010); op(39'h200, 39'h3020);
    op(39'h300, 39'h4000); op(39'h300, 39'h4100); op(39'h300, 39'h4200);
    for (int i = 0; i < 4; i++) push(39'h4400 + 39'(256 * i), 39'h300, 12'h100);
    op(39'h300, 39'h4300);
    op(39'h200, 39'h3030);
    wait_idle("drop_burst");
    chk("drop_count", 64'(drop_cnt), 64'd1);

    // Oversized deltas are mismatches, including one whose low bits equal the stride.
    op(39'h500, 39'h5000); op(39'h500, 39'h5010); op(39'h500, 39'h5020);
    op(39'h500, 39'h5820); op(39'h500, 39'h5830);
    for (int i = 0; i < 4; i++) push(39'h5850 + 39'(16 * i), 39'h500, 12'h010);
    op(39'h500, 39'h5840);
    wait_idle("delta_800");
    op(39'h600, 39'h6000); op(39'h600, 39'h6010); op(39'h600, 39'h6020);
    op(39'h600, 39'h7030); op(39'h600, 39'h7040);
    for (int i = 0; i < 4; i++) push(39'h7060 + 39'(16 * i), 39'h600, 12'h010);
    op(39'h600, 39'h7050);
    wait_idle("delta_1010");

    // Flush mid-burst with a coincident training op.
    mon_en = 1'b0;
    op(39'h900, 39'h9000); op(39'h900, 39'h9008); op(39'h900, 39'h9010); op(39'h900, 39'h9018);
    chk("flush_pre_pf_v", 64'(bus.pf_v_o), 64'd1);
    flush_i        = 1'b1;
    bus.mem_v_i    = 1'b1;
    bus.mem_pc_i   = 39'h900;
    bus.mem_addr_i = 39'h9020;
    @(posedge clk_i); #1;
    flush_i     = 1'b0;
    bus.mem_v_i = 1'b0;
    chk("flush_pf_v", 64'(bus.pf_v_o), 64'd0);
    chk("flush_busy", 64'(busy_o), 64'd0);
    mon_en = 1'b1;

    // Ninth allocation evicts entry 0; its PC must retrain from scratch.
    op(39'hA00, 39'hA000); op(39'hA00, 39'hA010); op(39'hA00, 39'hA020);
    for (int i = 1; i < 9; i++) op(39'hB00 + 39'(16 * i), 39'hC000);
    op(39'hA00, 39'hA030);
    op(39'hA00, 39'hA040); op(39'hA00, 39'hA050);
    for (int i = 0; i < 4; i++) push(39'hA070 + 39'(16 * i), 39'hA00, 12'h010);
    op(39'hA00, 39'hA060);
    wait_idle("evict");
    chk("final_drop_count", 64'(drop_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bp_be_stride_prefetch_engine.md
Name: bp_be_stride_prefetch_engine

Overview:
- Multi-stream stride detector and prefetch issuer in the BE, beside the load/store pipe.
- Trains a fully associative reference-prediction table on memory-op effective addresses.
- Tracks per-PC stride confidence; once a stream is steady, issues a burst of degree_p prefetch addresses through a valid/yumi handshake.
- Filters duplicate targets before issue.

Parameters:
- vaddr_width_p, 39, virtual address width.
- streams_p, 8, table entries, fully associative.
- stride_width_p, 12, signed stride width.
- conf_width_p, 2, saturating confidence counter width.
- conf_thresh_p, 2, post-update confidence at or above which a burst triggers.
- distance_p, 1, first prefetch multiple of stride.
- degree_p, 4, prefetches per burst.
- filter_els_p, 4, recently issued targets remembered for suppression.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- flush_i  in  1  invalidate table, abort burst
- mem_v_i  in  1  memory-op training input valid; always accepted
- mem_pc_i  in  vaddr_width_p  PC of the memory op
- mem_addr_i  in  vaddr_width_p  effective address
- pf_v_o  out  1  prefetch request valid
- pf_addr_o  out  vaddr_width_p  prefetch address
- pf_pc_o  out  vaddr_width_p  stream PC
- pf_stride_o  out  stride_width_p  stream stride
- pf_yumi_i  in  1  request consumed; legal only when pf_v_o
- busy_o  out  1  FSM in e_issue
- trigger_drop_o  out  1  one-cycle pulse: trigger lost because busy

Behaviour:
- Reset (or flush): all entries invalid, victim pointer 0, filter cleared, FSM e_idle. pf_v_o, busy_o, trigger_drop_o = 0. Data outputs = 0.
- Lookup: mem_v_i PC compared against all valid tags in the same cycle; the table is updated at the next edge.
- Miss:
  - allocate the lowest invalid entry; if none, the entry at the victim pointer, which then increments mod streams_p.
  - New entry: tag=pc, last=addr, stride=0, conf=0.
- Hit: delta = addr - last, truncated to stride_width_p signed.
  - If delta does not fit in stride_width_p, it is a mismatch.
  - Match (delta==stride): conf++ (saturate at 2^conf_width_p-1).
  - Mismatch: if conf==0, stride<=delta; else conf--.
  - In all hit cases last<=addr.
- Trigger: hit, match, stride!=0, and post-update conf>=conf_thresh_p.
  - In e_idle: latch base=addr, stride, pc, k=distance_p; enter e_issue at the next edge.
  - In e_issue: trigger is dropped and trigger_drop_o pulses next cycle.
- FSM e_issue:
  - target = base + k*sext(stride), mod 2^vaddr_width_p.
  - If target hits the filter: pf_v_o=0 and k advances this cycle.
  - Otherwise pf_v_o=1, held stable until pf_yumi_i. On yumi, target is pushed into the filter (FIFO, oldest evicted) and k advances.
  - After k=distance_p+degree_p-1 is consumed or skipped, return to e_idle. A new trigger is accepted that same cycle.
- Latency: training op at cycle t produces the first pf_v_o at cycle t+1 at the earliest.
- flush_i mid-burst: pf_v_o falls next cycle, no partial handshake. flush_i with mem_v_i: flush wins, op discarded.
- pf_pc_o and pf_stride_o are valid while pf_v_o is high, else 0.
- Address arithmetic wraps silently. Negative strides are supported.

Test Plan:
- Reset mid-burst: pf_v_o=0 the cycle after reset_i; first table access afterwards misses.
- PC 0x100 loads at 0x1000, 0x1040, 0x1080, 0x10C0 -> no pf_v_o after the first three. After the fourth (conf=2), pf_addr_o sequence 0x1100, 0x1140, 0x1180, 0x11C0 with yumi each cycle; busy_o falls afterwards.
- Continue with load 0x1100 -> targets 0x1140..0x11C0 suppressed by the filter; only 0x1200 issues.
- Negative stride: addresses 0x2000, 0x1FF8, 0x1FF0, 0x1FE8 -> prefetches 0x1FE0, 0x1FD8, 0x1FD0, 0x1FC8. Hold yumi low 3 cycles -> pf_addr_o stable at 0x1FE0.
- streams_p+1 distinct PCs, each once -> 9th allocation evicts entry 0; revisit of PC #0 is a miss.
- Second stream triggers during the first burst -> trigger_drop_o pulses once, the first burst completes unchanged. Delta 0x800 with stride_width_p=12 -> treated as mismatch, conf decrements.
